// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one SRAM controller port between the MEM-stage data requester (D,
// read/write) and the instruction-fetch requester (I, read-only). A grant is
// held until the downstream completion pulse or until the owner drops its
// request. One idle turnaround cycle always separates two grants.
//
// Build option: define ARB_ROUND_ROBIN_EN to replace fixed D priority plus the
// STARVE_LIMIT guard with a last-grant round-robin tie break.
module sram_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // data (MEM-stage) requester
    input  logic              d_rd_en,
    input  logic              d_wr_en,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    // instruction-fetch requester
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    // downstream SRAM controller port
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic d_req;
    logic i_req;
    logic i_wins;

    // A simultaneous read+write from D is treated as a write.
    assign d_req = d_rd_en | d_wr_en;
    assign i_req = i_rd_en;

`ifdef ARB_ROUND_ROBIN_EN
    // last_i_q = 1 means I received the most recent grant; resets to 1 so D
    // wins the first tie.
    logic last_i_q;
    logic last_i_d;

    assign i_wins = !d_req || !last_i_q;

    // Round-robin history register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_i_q <= 1'b1;
        end else begin
            last_i_q <= last_i_d;
        end
    end

    // Remember which requester won the latest IDLE arbitration
    always_comb begin
        last_i_d = last_i_q;
        if (state_q == IDLE && state_d == GNT_I) begin
            last_i_d = 1'b1;
        end else if (state_q == IDLE && state_d == GNT_D) begin
            last_i_d = 1'b0;
        end
    end
`else
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // Number of consecutive D grants taken while I was waiting.
    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;

    assign i_wins = !d_req || (starve_cnt_q == STARVE_MAX);

    // Starvation counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Count D wins over a waiting I (saturating); an I grant clears it
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE && state_d == GNT_I) begin
            starve_cnt_d = 4'd0;
        end else if (state_q == IDLE && state_d == GNT_D && i_req
                     && starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: arbitrate in IDLE, hold the grant until completion or abort
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_req && i_wins) begin
                    state_d = GNT_I;
                end else if (d_req) begin
                    state_d = GNT_D;
                end
            end
            GNT_D: begin
                if (!d_req || mem_ready) begin
                    state_d = IDLE;
                end
            end
            GNT_I: begin
                if (!i_req || mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Downstream port: steer the owner's signals, quiet when nobody owns it
    always_comb begin
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        case (state_q)
            GNT_D: begin
                mem_rd_en   = d_rd_en & ~d_wr_en;
                mem_wr_en   = d_wr_en;
                mem_address = d_address;
                mem_wdata   = d_wdata;
            end
            GNT_I: begin
                mem_rd_en   = 1'b1;
                mem_address = i_address;
            end
            default: begin
                mem_rd_en = 1'b0;
            end
        endcase
    end

    // Ready is high when idle-handed or at the owner's completion cycle;
    // mem_ready is only honoured while the matching grant is active.
    assign d_ready = !d_req || (state_q == GNT_D && mem_ready);
    assign i_ready = !i_req || (state_q == GNT_I && mem_ready);

    assign d_rdata = mem_rdata;
    assign i_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// Scoreboarded bench: each scenario pushes the grants it expects, in order,
// and a monitor pops one entry per downstream completion. A behavioural SRAM
// responder raises mem_ready after resp_lat granted cycles and returns
// 0x12345678 ^ address as read data.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_rd_en = 1'b0;
    logic        d_wr_en = 1'b0;
    logic [31:0] d_address = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        i_rd_en = 1'b0;
    logic [31:0] i_address = '0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    int resp_lat = 3;
    int resp_cnt = 0;
    bit idle_noise = 1'b0;

    typedef struct {
        bit          is_i;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    sram_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .d_rd_en(d_rd_en),
        .d_wr_en(d_wr_en),
        .d_address(d_address),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_ready(d_ready),
        .i_rd_en(i_rd_en),
        .i_address(i_address),
        .i_rdata(i_rdata),
        .i_ready(i_ready),
        .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en),
        .mem_address(mem_address),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    assign mem_rdata = 32'h1234_5678 ^ mem_address;

    function automatic exp_t mk(input bit is_i, input bit wr,
                                input logic [31:0] a, input logic [31:0] w);
        exp_t e;
        e.is_i  = is_i;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = w;
        return e;
    endfunction

    // SRAM responder: counts granted cycles, completes on the resp_lat-th one
    always begin
        @(posedge clk);
        #2;
        if (mem_rd_en || mem_wr_en) begin
            resp_cnt++;
            mem_ready = (resp_cnt == resp_lat);
        end else begin
            resp_cnt  = 0;
            mem_ready = idle_noise;
        end
    end

    // Scoreboard monitor: one entry per downstream completion
    always @(negedge clk) begin
        if (!rst && mem_ready && (mem_rd_en || mem_wr_en)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got rd=%0b wr=%0b addr=%h, required no completion",
                         mem_rd_en, mem_wr_en, mem_address);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_i) begin
                    if (mem_rd_en !== 1'b1 || mem_wr_en !== 1'b0 || mem_address !== mon_e.addr
                        || mem_wdata !== 32'h0 || i_ready !== 1'b1
                        || i_rdata !== (32'h1234_5678 ^ mon_e.addr) || d_ready !== !(d_rd_en | d_wr_en)) begin
                        errors++;
                        $display("FAIL sb_i_grant: got rd=%0b wr=%0b addr=%h wdata=%h i_ready=%0b i_rdata=%h d_ready=%0b, required I read addr=%h",
                                 mem_rd_en, mem_wr_en, mem_address, mem_wdata, i_ready, i_rdata, d_ready, mon_e.addr);
                    end
                end else begin
                    if (mem_rd_en !== !mon_e.wr || mem_wr_en !== mon_e.wr || mem_address !== mon_e.addr
                        || (mon_e.wr && mem_wdata !== mon_e.wdata) || d_ready !== 1'b1
                        || (!mon_e.wr && d_rdata !== (32'h1234_5678 ^ mon_e.addr))
                        || i_ready !== !i_rd_en) begin
                        errors++;
                        $display("FAIL sb_d_grant: got rd=%0b wr=%0b addr=%h wdata=%h d_ready=%0b d_rdata=%h i_ready=%0b, required D wr=%0b addr=%h wdata=%h",
                                 mem_rd_en, mem_wr_en, mem_address, mem_wdata, d_ready, d_rdata, i_ready,
                                 mon_e.wr, mon_e.addr, mon_e.wdata);
                    end
                end
                $display("txn %s %s addr=%h wdata=%h rdata=%h", mon_e.is_i ? "I" : "D",
                         mon_e.wr ? "WR" : "RD", mem_address, mem_wdata, mem_rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        d_rd_en = 1'b0;
        d_wr_en = 1'b0;
        i_rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Issue one D access and wait for d_ready; cyc = -1 on timeout
    task automatic d_txn(input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, output int cyc);
        d_wr_en   = wr;
        d_rd_en   = !wr;
        d_address = addr;
        d_wdata   = data;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (d_ready) break;
            if (cyc >= 300) begin
                cyc = -1;
                break;
            end
        end
        @(posedge clk);
        #1;
        d_rd_en = 1'b0;
        d_wr_en = 1'b0;
    endtask

    // Issue one I fetch and wait for i_ready; cyc = -1 on timeout
    task automatic i_txn(input logic [31:0] addr, output int cyc);
        i_rd_en   = 1'b1;
        i_address = addr;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (i_ready) break;
            if (cyc >= 300) begin
                cyc = -1;
                break;
            end
        end
        @(posedge clk);
        #1;
        i_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (d_ready !== 1'b1 || i_ready !== 1'b1 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0
            || mem_address !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle: got d_ready=%0b i_ready=%0b rd=%0b wr=%0b addr=%h wdata=%h, required 1 1 0 0 0 0",
                     d_ready, i_ready, mem_rd_en, mem_wr_en, mem_address, mem_wdata);
        end
        // a request pending during reset must not reach the port
        d_rd_en = 1'b1;
        d_address = 32'h44;
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b0 || mem_rd_en !== 1'b0 || mem_address !== 32'h0) begin
            errors++;
            $display("FAIL reset_req_held: got d_ready=%0b rd=%0b addr=%h, required 0 0 0",
                     d_ready, mem_rd_en, mem_address);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b1 || i_ready !== 1'b1 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: got d_ready=%0b i_ready=%0b rd=%0b wr=%0b, required 1 1 0 0",
                     d_ready, i_ready, mem_rd_en, mem_wr_en);
        end
        tick();
    endtask

    task automatic test_d_write();
        int cyc;
        int wr_cycles;
        int early_ready;
        int i_low;
        do_reset();
        resp_lat = 5;
        exp_q.push_back(mk(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF));
        d_wr_en = 1'b1;
        d_address = 32'h100;
        d_wdata = 32'hDEAD_BEEF;
        cyc = 0;
        wr_cycles = 0;
        early_ready = 0;
        i_low = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_wr_en === 1'b1 && mem_rd_en === 1'b0 && mem_address === 32'h100
                && mem_wdata === 32'hDEAD_BEEF) wr_cycles++;
            if (i_ready !== 1'b1) i_low++;
            if (d_ready === 1'b1) break;
            if (cyc >= 50) break;
        end
        tick();
        d_wr_en = 1'b0;
        checks++;
        if (cyc !== 6) begin
            errors++;
            $display("FAIL write_latency: got %0d cycles to d_ready, required 6", cyc);
        end
        checks++;
        if (wr_cycles !== 5) begin
            errors++;
            $display("FAIL write_mem_cycles: got %0d cycles of mem_wr_en at 0x100, required 5", wr_cycles);
        end
        checks++;
        if (i_low !== 0) begin
            errors++;
            $display("FAIL write_i_ready: got %0d cycles with i_ready low, required 0", i_low);
        end
        @(negedge clk);
        checks++;
        if (mem_wr_en !== 1'b0 || mem_address !== 32'h0 || d_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_release: got wr=%0b addr=%h d_ready=%0b, required 0 0 1",
                     mem_wr_en, mem_address, d_ready);
        end
        tick();
    endtask

    task automatic test_contention();
        int cyc;
        int i_high;
        do_reset();
        resp_lat = 3;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h40, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0, 32'h0));
        d_rd_en = 1'b1;
        d_address = 32'h40;
        i_rd_en = 1'b1;
        i_address = 32'h0;
        cyc = 0;
        i_high = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (i_ready !== 1'b0) i_high++;
            if (d_ready === 1'b1 || cyc >= 50) break;
        end
        checks++;
        if (cyc !== 4 || i_high !== 0) begin
            errors++;
            $display("FAIL contention_d_first: got d_ready after %0d cycles, i_ready high %0d cycles, required 4 and 0",
                     cyc, i_high);
        end
        tick();
        d_rd_en = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b0 || i_ready !== 1'b0) begin
            errors++;
            $display("FAIL contention_turnaround: got rd=%0b i_ready=%0b, required 0 0", mem_rd_en, i_ready);
        end
        @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b1 || mem_address !== 32'h0 || d_ready !== 1'b1) begin
            errors++;
            $display("FAIL contention_i_grant: got rd=%0b addr=%h d_ready=%0b, required 1 0 1",
                     mem_rd_en, mem_address, d_ready);
        end
        cyc = 1;
        while (i_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (i_ready !== 1'b1 || i_rdata !== 32'h1234_5678 || cyc !== 3) begin
            errors++;
            $display("FAIL contention_i_data: got i_ready=%0b i_rdata=%h after %0d grant cycles, required 1 12345678 3",
                     i_ready, i_rdata, cyc);
        end
        tick();
        i_rd_en = 1'b0;
    endtask

    task automatic test_starvation();
        int to_d;
        int to_i;
        int c;
        do_reset();
        resp_lat = 2;
        to_d = 0;
        to_i = 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_q.push_back(mk(1'b0, 1'b0, 32'h300, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h400, 32'h0));
        for (int k = 1; k < 6; k++) exp_q.push_back(mk(1'b0, 1'b0, 32'h300 + 32'(4 * k), 32'h0));
`else
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(1'b0, 1'b0, 32'h300 + 32'(4 * k), 32'h0));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h400, 32'h0));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h310, 32'h0));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h314, 32'h0));
`endif
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    d_txn(1'b0, 32'h300 + 32'(4 * k), 32'h0, c);
                    if (c < 0) to_d++;
                end
            end
            begin
                int ci;
                i_txn(32'h400, ci);
                if (ci < 0) to_i++;
            end
        join
        checks++;
        if (to_d !== 0 || to_i !== 0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL starvation_order: got d timeouts=%0d i timeouts=%0d pending=%0d, required 0 0 0",
                     to_d, to_i, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int to_cnt;
        do_reset();
        resp_lat = 2;
        to_cnt = 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_q.push_back(mk(1'b0, 1'b0, 32'h700, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h800, 32'h0));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h704, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h804, 32'h0));
`else
        exp_q.push_back(mk(1'b0, 1'b0, 32'h700, 32'h0));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h704, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h800, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h804, 32'h0));
`endif
        fork
            begin
                int cd;
                for (int k = 0; k < 2; k++) begin
                    d_txn(1'b0, 32'h700 + 32'(4 * k), 32'h0, cd);
                    if (cd < 0) to_cnt++;
                end
            end
            begin
                int cj;
                for (int k = 0; k < 2; k++) begin
                    i_txn(32'h800 + 32'(4 * k), cj);
                    if (cj < 0) to_cnt++;
                end
            end
        join
        checks++;
        if (to_cnt !== 0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL back_to_back_order: got timeouts=%0d pending=%0d, required 0 0",
                     to_cnt, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_grant();
        int c;
        do_reset();
        resp_lat = 100;
        fork
            d_txn(1'b0, 32'h200, 32'h0, c);
            begin
                repeat (3) @(negedge clk);
                checks++;
                if (mem_rd_en !== 1'b1 || mem_address !== 32'h200) begin
                    errors++;
                    $display("FAIL midreset_granted: got rd=%0b addr=%h, required 1 200", mem_rd_en, mem_address);
                end
                @(posedge clk);
                #3;
                rst = 1'b1;
                #1;
                checks++;
                if (mem_rd_en !== 1'b0 || mem_address !== 32'h0 || d_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_drop: got rd=%0b addr=%h d_ready=%0b, required 0 0 0",
                             mem_rd_en, mem_address, d_ready);
                end
                @(negedge clk);
                checks++;
                if (d_ready !== 1'b0 || mem_rd_en !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_no_ready: got d_ready=%0b rd=%0b, required 0 0", d_ready, mem_rd_en);
                end
                @(posedge clk);
                #3;
                resp_lat = 3;
                exp_q.push_back(mk(1'b0, 1'b0, 32'h200, 32'h0));
                rst = 1'b0;
            end
        join
        checks++;
        if (c < 0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL midreset_restart: got cycles=%0d pending=%0d, required completion and 0 pending",
                     c, exp_q.size());
        end
    endtask

    task automatic test_abort();
        int c;
        do_reset();
        resp_lat = 100;
        d_wr_en = 1'b1;
        d_address = 32'h500;
        d_wdata = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_wr_en !== 1'b1 || mem_address !== 32'h500 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_granted: got wr=%0b addr=%h d_ready=%0b, required 1 500 0",
                     mem_wr_en, mem_address, d_ready);
        end
        tick();
        d_wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0 || d_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_drop: got wr=%0b rd=%0b d_ready=%0b, required 0 0 1",
                     mem_wr_en, mem_rd_en, d_ready);
        end
        @(negedge clk);
        checks++;
        if (mem_address !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL abort_idle: got addr=%h wdata=%h, required 0 0", mem_address, mem_wdata);
        end
        tick();
        resp_lat = 2;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h504, 32'h0));
        d_txn(1'b0, 32'h504, 32'h0, c);
        checks++;
        if (c !== 3) begin
            errors++;
            $display("FAIL abort_recover: got %0d cycles to d_ready, required 3", c);
        end
    endtask

    task automatic test_idle_ready_ignored();
        int c;
        int bad;
        do_reset();
        resp_lat = 2;
        idle_noise = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0 || d_ready !== 1'b1 || i_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_noise_quiet: got %0d disturbed cycles, required 0", bad);
        end
        tick();
        exp_q.push_back(mk(1'b1, 1'b0, 32'h600, 32'h0));
        i_txn(32'h600, c);
        checks++;
        if (c !== 3) begin
            errors++;
            $display("FAIL idle_noise_latency: got %0d cycles to i_ready, required 3", c);
        end
        idle_noise = 1'b0;
    endtask

    initial begin
        test_reset();
        test_d_write();
        test_contention();
        test_starvation();
        test_back_to_back();
        test_reset_mid_grant();
        test_abort();
        test_idle_ready_ignored();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d expected grants never seen, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at 200000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
